// File: rtl/vending_pkg.sv
// Shared types and helpers for the vending controller: coin codes, FSM states
// and the coin-code to credit-unit mapping.
package vending_pkg;

  typedef enum logic [1:0] {
    COIN_5   = 2'd0,
    COIN_10  = 2'd1,
    COIN_25  = 2'd2,
    COIN_BAD = 2'd3
  } coin_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vend_state_t;

  // Wide enough for the largest coin (25).
  localparam int COIN_VAL_W = 5;

  function automatic logic [COIN_VAL_W-1:0] coin_value(input coin_t c);
    case (c)
      COIN_5:  return 5'd5;
      COIN_10: return 5'd10;
      COIN_25: return 5'd25;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_stock.sv
// Per-slot stock counters with bulk restock, single-slot decrement and a
// registered sold-out flag per slot that always matches the counter value.
module vending_stock
  import vending_pkg::*;
#(
  parameter int NUM_ITEMS   = 4,
  parameter int STOCK_DEPTH = 8,
  parameter int SEL_W       = $clog2(NUM_ITEMS),
  parameter int STOCK_W     = $clog2(STOCK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restock,
  input  logic                 dec,
  input  logic [SEL_W-1:0]     dec_item,
  output logic [NUM_ITEMS-1:0] sold_out
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_slot
      logic [STOCK_W-1:0] cnt_reg, cnt_next;
      logic               empty_reg;

      always_comb begin
        cnt_next = cnt_reg;
        if (restock)
          cnt_next = STOCK_W'(STOCK_DEPTH);
        else if (dec && (dec_item == SEL_W'(gi)) && (cnt_reg != '0))
          cnt_next = cnt_reg - STOCK_W'(1);
      end

      // The empty flag is loaded from cnt_next so it never lags the counter.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg   <= STOCK_W'(STOCK_DEPTH);
          empty_reg <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          empty_reg <= (cnt_next == '0);
        end
      end

      assign sold_out[gi] = empty_reg;
    end
  endgenerate

endmodule

// File: rtl/vending_ctrl.sv
// Multi-item vending controller: credit accumulator, selection/vend FSM and
// change return. Define VEND_STATS_EN to add the sales_cnt/refund_cnt outputs.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int PRICE       = 15,
  parameter int MAX_CREDIT  = 50,
  parameter int NUM_ITEMS   = 4,
  parameter int STOCK_DEPTH = 8,
  parameter int CREDIT_W    = $clog2(MAX_CREDIT + 1),
  parameter int SEL_W       = $clog2(NUM_ITEMS),
  parameter int STOCK_W     = $clog2(STOCK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coin_valid,
  input  logic [1:0]           coin,
  input  logic                 sel_valid,
  input  logic [SEL_W-1:0]     sel_item,
  input  logic                 cancel,
  input  logic                 change_ack,
  input  logic                 restock,
  output logic                 dispense,
  output logic [SEL_W-1:0]     disp_item,
  output logic                 change_valid,
  output logic [CREDIT_W-1:0]  change_amt,
  output logic                 coin_reject,
  output logic                 sel_reject,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] sold_out
`ifdef VEND_STATS_EN
  ,
  output logic [15:0]          sales_cnt,
  output logic [15:0]          refund_cnt
`endif
);

  // One spare bit above the credit width so an overflowing coin is detectable.
  localparam int SUM_W = (CREDIT_W + 1 > COIN_VAL_W) ? CREDIT_W + 1 : COIN_VAL_W;

  vend_state_t         state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic                dispense_reg, dispense_next;
  logic [SEL_W-1:0]    disp_item_reg, disp_item_next;
  logic                change_valid_reg, change_valid_next;
  logic [CREDIT_W-1:0] change_amt_reg, change_amt_next;
  logic                coin_reject_reg, coin_reject_next;
  logic                sel_reject_reg, sel_reject_next;
  logic                stock_dec, restock_en, cancel_acc;
  logic [SUM_W-1:0]    coin_sum;
  logic                coin_ok, sel_ok;

  assign coin_sum = SUM_W'(credit_reg) + SUM_W'(coin_value(coin_t'(coin)));
  assign coin_ok  = (coin_t'(coin) != COIN_BAD) && (coin_sum <= SUM_W'(MAX_CREDIT));
  assign sel_ok   = (state_reg == COLLECT) && (credit_reg >= CREDIT_W'(PRICE)) &&
                    ({1'b0, sel_item} < (SEL_W + 1)'(NUM_ITEMS)) && !sold_out[sel_item];

  always_comb begin
    state_next        = state_reg;
    credit_next       = credit_reg;
    dispense_next     = 1'b0;
    disp_item_next    = disp_item_reg;
    change_valid_next = change_valid_reg;
    change_amt_next   = change_amt_reg;
    coin_reject_next  = 1'b0;
    sel_reject_next   = 1'b0;
    stock_dec         = 1'b0;
    restock_en        = 1'b0;
    cancel_acc        = 1'b0;
    case (state_reg)
      IDLE, COLLECT: begin
        restock_en = restock && (state_reg == IDLE);
        if (cancel && (state_reg == COLLECT)) begin
          state_next        = CHANGE;
          change_valid_next = 1'b1;
          change_amt_next   = credit_reg;
          cancel_acc        = 1'b1;
          coin_reject_next  = coin_valid;
        end else begin
          if (sel_valid) begin
            if (sel_ok) begin
              state_next     = VEND;
              dispense_next  = 1'b1;
              disp_item_next = sel_item;
              credit_next    = credit_reg - CREDIT_W'(PRICE);
              stock_dec      = 1'b1;
            end else begin
              sel_reject_next = 1'b1;
            end
          end
          // A refused selection does not consume the cycle, so the coin is still evaluated.
          if (coin_valid) begin
            if (sel_valid && sel_ok) begin
              coin_reject_next = 1'b1;
            end else if (coin_ok) begin
              credit_next = coin_sum[CREDIT_W-1:0];
              state_next  = COLLECT;
            end else begin
              coin_reject_next = 1'b1;
            end
          end
        end
      end
      VEND: begin
        coin_reject_next = coin_valid;
        sel_reject_next  = sel_valid;
        if (credit_reg != '0) begin
          state_next        = CHANGE;
          change_valid_next = 1'b1;
          change_amt_next   = credit_reg;
        end else begin
          state_next = IDLE;
        end
      end
      CHANGE: begin
        coin_reject_next = coin_valid;
        sel_reject_next  = sel_valid;
        if (change_ack) begin
          state_next        = IDLE;
          credit_next       = '0;
          change_valid_next = 1'b0;
          change_amt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      credit_reg       <= '0;
      dispense_reg     <= 1'b0;
      disp_item_reg    <= '0;
      change_valid_reg <= 1'b0;
      change_amt_reg   <= '0;
      coin_reject_reg  <= 1'b0;
      sel_reject_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      credit_reg       <= credit_next;
      dispense_reg     <= dispense_next;
      disp_item_reg    <= disp_item_next;
      change_valid_reg <= change_valid_next;
      change_amt_reg   <= change_amt_next;
      coin_reject_reg  <= coin_reject_next;
      sel_reject_reg   <= sel_reject_next;
    end
  end

  vending_stock #(
    .NUM_ITEMS  (NUM_ITEMS),
    .STOCK_DEPTH(STOCK_DEPTH),
    .SEL_W      (SEL_W),
    .STOCK_W    (STOCK_W)
  ) u_stock (
    .clk     (clk),
    .rst     (rst),
    .restock (restock_en),
    .dec     (stock_dec),
    .dec_item(sel_item),
    .sold_out(sold_out)
  );

  assign dispense     = dispense_reg;
  assign disp_item    = disp_item_reg;
  assign change_valid = change_valid_reg;
  assign change_amt   = change_amt_reg;
  assign coin_reject  = coin_reject_reg;
  assign sel_reject   = sel_reject_reg;
  assign credit       = credit_reg;

`ifdef VEND_STATS_EN
  logic [15:0] sales_reg, refund_reg;

  // Counted on the accepting edge so sales_cnt steps together with dispense.
  always_ff @(posedge clk) begin
    if (rst) begin
      sales_reg  <= '0;
      refund_reg <= '0;
    end else begin
      if (dispense_next && (sales_reg != 16'hFFFF))
        sales_reg <= sales_reg + 16'd1;
      if (cancel_acc && (refund_reg != 16'hFFFF))
        refund_reg <= refund_reg + 16'd1;
    end
  end

  assign sales_cnt  = sales_reg;
  assign refund_cnt = refund_reg;
`endif

endmodule

// File: tb/tb_vending_ctrl.sv
// Self-checking bench for vending_ctrl: a transaction-level model compared every
// cycle, plus pinned literal expectations. Honours VEND_STATS_EN when defined.
module tb_vending_ctrl;

  localparam int PRICE       = 15;
  localparam int MAX_CREDIT  = 50;
  localparam int NUM_ITEMS   = 4;
  localparam int STOCK_DEPTH = 8;
  localparam int CREDIT_W    = $clog2(MAX_CREDIT + 1);
  localparam int SEL_W       = $clog2(NUM_ITEMS);
`ifdef VEND_STATS_EN
  localparam int NUM_SIG = 10;
`else
  localparam int NUM_SIG = 8;
`endif

  localparam int S_CREDIT = 0, S_DISP = 1, S_DITEM = 2, S_CVALID = 3, S_CAMT = 4,
                 S_CREJ = 5, S_SREJ = 6, S_SOLD = 7, S_SALES = 8, S_REFUND = 9;

  logic                 clk, rst, coin_valid, sel_valid, cancel, change_ack, restock;
  logic [1:0]           coin;
  logic [SEL_W-1:0]     sel_item;
  logic                 dispense, change_valid, coin_reject, sel_reject;
  logic [SEL_W-1:0]     disp_item;
  logic [CREDIT_W-1:0]  change_amt, credit;
  logic [NUM_ITEMS-1:0] sold_out;
`ifdef VEND_STATS_EN
  logic [15:0]          sales_cnt, refund_cnt;
`endif

  vending_ctrl #(
    .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .NUM_ITEMS(NUM_ITEMS), .STOCK_DEPTH(STOCK_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
    .change_ack(change_ack), .restock(restock), .dispense(dispense),
    .disp_item(disp_item), .change_valid(change_valid), .change_amt(change_amt),
    .coin_reject(coin_reject), .sel_reject(sel_reject), .credit(credit),
    .sold_out(sold_out)
`ifdef VEND_STATS_EN
    , .sales_cnt(sales_cnt), .refund_cnt(refund_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: credit held, amount owed back, whether a vend or refund is in progress.
  int m_credit, m_amt, m_disp_item, m_sales, m_refunds;
  bit m_disp, m_crej, m_srej, m_vending, m_returning;
  int m_stock [NUM_ITEMS];

  int pin_id  [512];
  int pin_val [512];
  int pin_wr = 0;
  bit chk_on = 1'b0;

  function automatic string sig_name(input int id);
    case (id)
      S_CREDIT: return "credit";
      S_DISP:   return "dispense";
      S_DITEM:  return "disp_item";
      S_CVALID: return "change_valid";
      S_CAMT:   return "change_amt";
      S_CREJ:   return "coin_reject";
      S_SREJ:   return "sel_reject";
      S_SOLD:   return "sold_out";
      S_SALES:  return "sales_cnt";
      default:  return "refund_cnt";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int id);
    case (id)
      S_CREDIT: return 32'(credit);
      S_DISP:   return 32'(dispense);
      S_DITEM:  return 32'(disp_item);
      S_CVALID: return 32'(change_valid);
      S_CAMT:   return 32'(change_amt);
      S_CREJ:   return 32'(coin_reject);
      S_SREJ:   return 32'(sel_reject);
      S_SOLD:   return 32'(sold_out);
`ifdef VEND_STATS_EN
      S_SALES:  return 32'(sales_cnt);
      S_REFUND: return 32'(refund_cnt);
`endif
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] expected(input int id);
    int so;
    so = 0;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (m_stock[i] == 0) so = so | (1 << i);
    case (id)
      S_CREDIT: return 32'(m_credit);
      S_DISP:   return 32'(m_disp);
      S_DITEM:  return 32'(m_disp_item);
      S_CVALID: return 32'(m_returning);
      S_CAMT:   return 32'(m_amt);
      S_CREJ:   return 32'(m_crej);
      S_SREJ:   return 32'(m_srej);
      S_SOLD:   return 32'(so);
      S_SALES:  return 32'(m_sales);
      S_REFUND: return 32'(m_refunds);
      default:  return 32'h0;
    endcase
  endfunction

  // Compare process: all outputs against the model, then any pinned literals.
  initial begin : compare
    int pin_rd;
    pin_rd = 0;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int id = 0; id < NUM_SIG; id++) begin
          checks++;
          if (actual(id) !== expected(id)) begin
            errors++;
            $display("FAIL model_%s at %0t: got %0d expected %0d",
                     sig_name(id), $time, actual(id), expected(id));
          end
        end
        while (pin_rd < pin_wr) begin
          checks++;
          if (actual(pin_id[pin_rd]) !== 32'(pin_val[pin_rd])) begin
            errors++;
            $display("FAIL pin_%s at %0t: got %0d expected %0d",
                     sig_name(pin_id[pin_rd]), $time, actual(pin_id[pin_rd]), pin_val[pin_rd]);
          end
          pin_rd++;
        end
      end
    end
  end

  task automatic model_step();
    int c0, v;
    bit taken;
    m_disp = 1'b0;
    m_crej = 1'b0;
    m_srej = 1'b0;
    if (rst) begin
      m_credit = 0; m_amt = 0; m_disp_item = 0; m_sales = 0; m_refunds = 0;
      m_vending = 1'b0; m_returning = 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = STOCK_DEPTH;
    end else if (m_vending) begin
      m_crej = coin_valid;
      m_srej = sel_valid;
      m_vending = 1'b0;
      if (m_credit > 0) begin
        m_returning = 1'b1;
        m_amt = m_credit;
      end
    end else if (m_returning) begin
      m_crej = coin_valid;
      m_srej = sel_valid;
      if (change_ack) begin
        m_credit = 0; m_amt = 0; m_returning = 1'b0;
      end
    end else begin
      c0 = m_credit;
      taken = 1'b0;
      if (cancel && c0 > 0) begin
        m_returning = 1'b1; m_amt = c0; taken = 1'b1;
        if (m_refunds < 65535) m_refunds++;
      end else if (sel_valid) begin
        if (c0 >= PRICE && m_stock[sel_item] > 0) begin
          m_stock[sel_item]--;
          m_credit = c0 - PRICE;
          m_vending = 1'b1; m_disp = 1'b1; m_disp_item = int'(sel_item); taken = 1'b1;
          if (m_sales < 65535) m_sales++;
        end else begin
          m_srej = 1'b1;
        end
      end
      if (coin_valid) begin
        v = (coin == 2'd0) ? 5 : (coin == 2'd1) ? 10 : (coin == 2'd2) ? 25 : -1;
        if (taken || v < 0 || c0 + v > MAX_CREDIT) m_crej = 1'b1;
        else m_credit = c0 + v;
      end
      if (restock && c0 == 0)
        for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = STOCK_DEPTH;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; change_ack = 1'b0; restock = 1'b0;
  endtask

  task automatic pin(input int id, input int v);
    pin_id[pin_wr]  = id;
    pin_val[pin_wr] = v;
    pin_wr++;
  endtask

  task automatic put_coin(input int c);
    coin_valid = 1'b1; coin = 2'(c); cyc();
  endtask

  task automatic select(input int i);
    sel_valid = 1'b1; sel_item = SEL_W'(i); cyc();
  endtask

  task automatic do_cancel();
    cancel = 1'b1; cyc();
  endtask

  task automatic do_ack();
    change_ack = 1'b1; cyc();
  endtask

  // 10 + 5 = exact price, so the vend returns straight to IDLE.
  task automatic vend_one(input int i);
    put_coin(1); put_coin(0); select(i); cyc();
  endtask

  initial begin : driver
    rst = 1'b1; coin_valid = 1'b0; coin = 2'd0; sel_valid = 1'b0; sel_item = '0;
    cancel = 1'b0; change_ack = 1'b0; restock = 1'b0;
    cyc();
    chk_on = 1'b1;
    cyc();
    pin(S_CREDIT, 0); pin(S_CVALID, 0); pin(S_SOLD, 0); pin(S_DISP, 0); pin(S_CAMT, 0);
    rst = 1'b0;

    // 10 + 10, select slot 2, change of 5
    put_coin(1); put_coin(1);
    pin(S_CREDIT, 20);
    select(2);
    pin(S_DISP, 1); pin(S_DITEM, 2); pin(S_CREDIT, 5);
    cyc();
    pin(S_DISP, 0); pin(S_CVALID, 1); pin(S_CAMT, 5);
    cyc();
    pin(S_CVALID, 1);
    do_ack();
    pin(S_CREDIT, 0); pin(S_CVALID, 0); pin(S_CAMT, 0);

    // 5 + 10, exact price, then overflow reject at 30 + 25
    put_coin(0); put_coin(1); select(0);
    pin(S_DISP, 1); pin(S_DITEM, 0); pin(S_CREDIT, 0);
    cyc();
    pin(S_CVALID, 0);
    put_coin(2); put_coin(0);
    pin(S_CREDIT, 30);
    put_coin(2);
    pin(S_CREJ, 1); pin(S_CREDIT, 30);
    do_cancel();
    pin(S_CAMT, 30);
    do_ack();

    // invalid coin code in IDLE
    put_coin(3);
    pin(S_CREJ, 1); pin(S_CREDIT, 0);

    // insufficient credit, cancel, coin during CHANGE
    put_coin(1); select(1);
    pin(S_SREJ, 1); pin(S_CREDIT, 10); pin(S_DISP, 0);
    do_cancel();
    pin(S_CVALID, 1); pin(S_CAMT, 10);
    put_coin(0);
    pin(S_CREJ, 1); pin(S_CVALID, 1); pin(S_CREDIT, 10);
    do_ack();

    // exhaust slot 1, refused ninth selection, restock
    for (int k = 0; k < STOCK_DEPTH; k++) vend_one(1);
    pin(S_SOLD, 2);
    put_coin(1); put_coin(0); select(1);
    pin(S_SREJ, 1); pin(S_CREDIT, 15);
    do_cancel(); do_ack();
    restock = 1'b1; cyc();
    pin(S_SOLD, 0);

    // cancel + select + coin together with credit 25
    put_coin(2);
    cancel = 1'b1; sel_valid = 1'b1; sel_item = SEL_W'(0); coin_valid = 1'b1; coin = 2'd0;
    cyc();
    pin(S_CVALID, 1); pin(S_CAMT, 25); pin(S_CREJ, 1); pin(S_DISP, 0); pin(S_SREJ, 0);
    do_ack();

    // exhaust slot 3, then reset while in CHANGE
    for (int k = 0; k < STOCK_DEPTH; k++) vend_one(3);
    pin(S_SOLD, 8);
    put_coin(1); do_cancel();
    pin(S_CVALID, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    pin(S_CREDIT, 0); pin(S_CVALID, 0); pin(S_CAMT, 0); pin(S_SOLD, 0);
`ifdef VEND_STATS_EN
    pin(S_SALES, 0); pin(S_REFUND, 0);
`endif
    vend_one(3);
    pin(S_SOLD, 0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
